inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/cpu_pkg.sv | 6 +
 rtl/inst_fetch_ctrl_if.sv | 11 +
 rtl/ret_stack.sv | 27 ++
 rtl/inst_fetch_ctrl.sv | 70 +++++++
 tb/tb_inst_fetch_ctrl.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-controller types and width defaults
package cpu_pkg;
   localparam int PC_W_DEF = 8;
   localparam int INST_W = 16;
   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// inst_fetch_ctrl_if: instruction-memory port plus fetch-to-decode valid/ready handshake
interface inst_fetch_ctrl_if #(parameter int PC_W = cpu_pkg::PC_W_DEF);
   logic [PC_W-1:0] mem_pc;
   logic [cpu_pkg::INST_W-1:0] mem_inst;
   logic [cpu_pkg::INST_W-1:0] inst_out;
   logic [PC_W-1:0] inst_pc;
   logic inst_valid;
   logic inst_ready;
   modport master (output mem_pc, inst_out, inst_pc, inst_valid, input mem_inst, inst_ready);
   modport slave (input mem_pc, inst_out, inst_pc, inst_valid, output mem_inst, inst_ready);
endinterface

// File: rtl/ret_stack.sv
// ret_stack: LIFO of return addresses; top entry is always visible on dout
module ret_stack #(
   parameter int DEPTH = 4,
   parameter int W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0] sp;
   assign full = sp == (AW+1)'(DEPTH);
   assign empty = sp == '0;
   assign dout = mem[AW'(sp - (AW+1)'(1))];
   always_ff @(posedge clk or posedge rst)
      if (rst) sp <= '0;
      else if (push) sp <= sp + (AW+1)'(1);
      else if (pop) sp <= sp - (AW+1)'(1);
   always_ff @(posedge clk)
      if (push) mem[sp[AW-1:0]] <= din;
endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: sequential fetch with stall, branch/call/return redirect and halt/resume
module inst_fetch_ctrl import cpu_pkg::*; #(
   parameter int PC_W = PC_W_DEF,
   parameter int STK_DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic halt,
   input  logic br_en,
   input  logic [PC_W-1:0] br_target,
   input  logic call_en,
   input  logic ret_en,
   output logic stk_err,
   inst_fetch_ctrl_if.master bus
);
   state_t state, state_nx;
   logic [PC_W-1:0] fetch_pc, stk_top;
   logic run, do_halt, do_ret, do_call, do_br, do_load, push, pop, full, empty;
   assign bus.mem_pc = fetch_pc;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = (state == IDLE) ? (start ? RUN : IDLE) :
                 (state == RUN) ? (halt ? HALTED : RUN) :
                 (start && !halt) ? RUN : HALTED;
   end
   always_comb begin
      run = state == RUN;
      do_halt = run && halt;
      do_ret = run && !halt && ret_en;
      do_call = run && !halt && !ret_en && call_en;
      do_br = run && !halt && !ret_en && !call_en && br_en;
      do_load = run && !halt && !ret_en && !call_en && !br_en && (!bus.inst_valid || bus.inst_ready);
      push = do_call && !full;
      pop = do_ret && !empty;
   end
   // later assignments win: redirect/halt override the sequential load
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         fetch_pc <= '0;
         bus.inst_out <= '0;
         bus.inst_pc <= '0;
         bus.inst_valid <= 1'b0;
         stk_err <= 1'b0;
      end else begin
         if (do_load) begin
            bus.inst_out <= bus.mem_inst;
            bus.inst_pc <= fetch_pc;
            bus.inst_valid <= 1'b1;
            fetch_pc <= fetch_pc + PC_W'(2);
         end
         if (do_halt || do_ret || do_call || do_br) bus.inst_valid <= 1'b0;
         if (do_halt && bus.inst_valid && !bus.inst_ready) fetch_pc <= bus.inst_pc;
         if (do_ret) fetch_pc <= empty ? '0 : stk_top;
         if (do_call || do_br) fetch_pc <= br_target;
         if ((do_call && full) || (do_ret && empty)) stk_err <= 1'b1;
      end
   ret_stack #(.DEPTH(STK_DEPTH), .W(PC_W)) u_stk (
      .clk(clk),
      .rst(rst),
      .push(push),
      .pop(pop),
      .din(bus.inst_pc + PC_W'(2)),
      .dout(stk_top),
      .full(full),
      .empty(empty)
   );
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed vectors against a byte-addressed memory model
module tb_inst_fetch_ctrl;
   logic clk = 1'b0;
   logic rst, start, halt, br_en, call_en, ret_en, stk_err;
   logic [7:0] br_target;
   logic [7:0] mem [256];
   logic [7:0] pc_nx;
   logic [7:0] ret_exp [4];
   int n_tests = 0;
   int n_fail = 0;
   inst_fetch_ctrl_if #(.PC_W(8)) bus ();
   inst_fetch_ctrl #(.PC_W(8), .STK_DEPTH(4)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .halt(halt),
      .br_en(br_en),
      .br_target(br_target),
      .call_en(call_en),
      .ret_en(ret_en),
      .stk_err(stk_err),
      .bus(bus)
   );
   always #5 clk = ~clk;
   assign pc_nx = bus.mem_pc + 8'd1;
   assign bus.mem_inst = {mem[bus.mem_pc], mem[pc_nx]};
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst = 1'b1; start = 1'b0; halt = 1'b0; br_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
      br_target = '0; bus.inst_ready = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      mem[0] = 8'hF0; mem[1] = 8'h0F; mem[2] = 8'hF4; mem[3] = 8'h01;
      ret_exp[0] = 8'h52; ret_exp[1] = 8'h42; ret_exp[2] = 8'h32; ret_exp[3] = 8'h02;
      #1;
      check("rst_valid", bus.inst_valid, 0);
      check("rst_mem_pc", bus.mem_pc, 0);
      check("rst_inst_out", bus.inst_out, 0);
      check("rst_inst_pc", bus.inst_pc, 0);
      check("rst_stk_err", stk_err, 0);
      step; rst = 1'b0; start = 1'b1; bus.inst_ready = 1'b1;
      step; start = 1'b0;
      check("start_valid", bus.inst_valid, 0);
      check("start_mem_pc", bus.mem_pc, 0);
      step;
      check("first_out", bus.inst_out, 16'hF00F);
      check("first_pc", bus.inst_pc, 0);
      check("first_valid", bus.inst_valid, 1);
      step;
      check("second_out", bus.inst_out, 16'hF401);
      check("second_pc", bus.inst_pc, 2);
      check("second_mem_pc", bus.mem_pc, 4);
      bus.inst_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step;
         check("stall_out", bus.inst_out, 16'hF401);
         check("stall_pc", bus.inst_pc, 2);
         check("stall_mem_pc", bus.mem_pc, 4);
         check("stall_valid", bus.inst_valid, 1);
      end
      bus.inst_ready = 1'b1;
      step;
      check("release_out", bus.inst_out, 16'h0405);
      check("release_pc", bus.inst_pc, 4);
      step; step;
      check("pre_call_pc", bus.inst_pc, 8);
      call_en = 1'b1; br_target = 8'd20;
      step; call_en = 1'b0;
      check("call_bubble", bus.inst_valid, 0);
      check("call_mem_pc", bus.mem_pc, 20);
      step;
      check("call_tgt_pc", bus.inst_pc, 20);
      check("call_tgt_out", bus.inst_out, 16'h1415);
      check("call_tgt_valid", bus.inst_valid, 1);
      step;
      check("sub_pc", bus.inst_pc, 22);
      ret_en = 1'b1;
      step; ret_en = 1'b0;
      check("ret_bubble", bus.inst_valid, 0);
      check("ret_mem_pc", bus.mem_pc, 10);
      step;
      check("ret_pc", bus.inst_pc, 10);
      check("ret_out", bus.inst_out, 16'h0A0B);
      check("ret_no_err", stk_err, 0);
      br_en = 1'b1; br_target = 8'd254;
      step; br_en = 1'b0;
      check("br_mem_pc", bus.mem_pc, 254);
      step;
      check("wrap_pc_fe", bus.inst_pc, 254);
      check("wrap_out_fe", bus.inst_out, 16'hFEFF);
      check("wrap_mem_pc", bus.mem_pc, 0);
      step;
      check("wrap_pc_0", bus.inst_pc, 0);
      check("wrap_out_0", bus.inst_out, 16'hF00F);
      for (int k = 0; k < 5; k++) begin
         br_target = 8'h30 + 8'(16 * k);
         call_en = 1'b1;
         step; call_en = 1'b0;
         check("nest_call_mem_pc", bus.mem_pc, 32'h30 + 32'(16 * k));
         check("nest_stk_err", stk_err, (k == 4) ? 1 : 0);
         step;
         check("nest_call_pc", bus.inst_pc, 32'h30 + 32'(16 * k));
      end
      for (int k = 0; k < 4; k++) begin
         ret_en = 1'b1;
         step; ret_en = 1'b0;
         check("nest_ret_mem_pc", bus.mem_pc, ret_exp[k]);
         step;
         check("nest_ret_pc", bus.inst_pc, ret_exp[k]);
      end
      ret_en = 1'b1;
      step; ret_en = 1'b0;
      check("empty_ret_mem_pc", bus.mem_pc, 0);
      check("empty_ret_err", stk_err, 1);
      repeat (4) step;
      check("pre_halt_pc", bus.inst_pc, 6);
      bus.inst_ready = 1'b0;
      step;
      check("halt_stall_pc", bus.inst_pc, 6);
      check("halt_stall_mem_pc", bus.mem_pc, 8);
      halt = 1'b1;
      step; halt = 1'b0;
      check("halted_valid", bus.inst_valid, 0);
      check("halted_mem_pc", bus.mem_pc, 6);
      br_en = 1'b1; br_target = 8'h80;
      step; br_en = 1'b0;
      check("halted_br_ignored", bus.mem_pc, 6);
      start = 1'b1;
      step; start = 1'b0;
      check("resume_valid", bus.inst_valid, 0);
      check("resume_mem_pc", bus.mem_pc, 6);
      bus.inst_ready = 1'b1;
      step;
      check("refetch_pc", bus.inst_pc, 6);
      check("refetch_out", bus.inst_out, 16'h0607);
      check("refetch_valid", bus.inst_valid, 1);
      step;
      #3 rst = 1'b1;
      #1;
      check("mid_rst_valid", bus.inst_valid, 0);
      check("mid_rst_out", bus.inst_out, 0);
      check("mid_rst_pc", bus.inst_pc, 0);
      check("mid_rst_mem_pc", bus.mem_pc, 0);
      check("mid_rst_err", stk_err, 0);
      step; rst = 1'b0;
      step;
      check("post_rst_idle_valid", bus.inst_valid, 0);
      check("post_rst_idle_mem_pc", bus.mem_pc, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
